mem_port_arbiter: RTL and testbench

Sequencer that shares the single physical memory port between the instruction-fetch stage and the MEM stage (load/store, per `mem_read`/`mem_write` of the control word). It accepts one request at a time from each side, latches it, drives one physical transaction, and returns the response to the owning requester. Data requests take priority; an optional starvation guard guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical memory port between instruction fetch
// and the MEM stage. Data requests win; the optional fetch-starvation guard is
// compiled in with `define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state;
  logic   d_req;
  logic   force_i;
  logic   grant_d;
  logic   grant_i;

  assign d_req = d_read | d_write;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign force_i = (starve_cnt == 8'(STARVE_LIMIT));

  // Count data grants that bypass a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_read && !force_i) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  logic unused_limit;

  assign force_i      = 1'b0;
  assign unused_limit = ^8'(STARVE_LIMIT);
`endif

  // Grant decision in IDLE: data first unless the guard forces the fetch.
  always_comb begin
    grant_d = (state == IDLE) && d_req && !(i_read && force_i);
    grant_i = (state == IDLE) && i_read && !grant_d;
  end

  // Arbiter FSM; the pmem_* outputs are the request latched at grant time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            // Read+write together is illegal; it is treated as a write.
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            pmem_wmask   <= d_wmask;
          end else if (grant_i) begin
            state        <= SERVE_I;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= i_address;
            pmem_wdata   <= '0;
            pmem_wmask   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Responses pass straight through; a request dropped early loses its resp.
  always_comb begin
    i_resp  = (state == SERVE_I) && pmem_resp && i_read;
    d_resp  = (state == SERVE_D) && pmem_resp && d_req;
    i_rdata = i_resp ? pmem_rdata : '0;
    d_rdata = d_resp ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with programmable latency, a
// response scoreboard, and directed cycle checks.
module tb_mem_port_arbiter;
  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors    = 0;
  int   checks    = 0;
  int   resp_cnt  = 0;
  int   exp_resps = 0;
  int   mem_lat   = 1;
  logic prev_resp = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return (addr == 32'h40) ? 32'hDEAD_BEEF : (addr ^ 32'hC0DE_0000);
  endfunction

  task automatic check_eq(input string tag, input logic [159:0] got,
                          input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_resp(input logic is_d, input logic [31:0] rdata);
    sb.push_back('{is_d, rdata});
    exp_resps++;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("resp_count", 160'(resp_cnt), 160'(target));
  endtask

  // Memory model: responds mem_lat cycles after the strobe first appears.
  initial begin
    int cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n || pmem_resp) begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cnt        = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_data(pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp pulse.
  always @(negedge clk) begin
    if (prev_resp) check_eq("strobe_drop", {pmem_read, pmem_write}, 2'b00);
    prev_resp = 1'b0;
    if (i_resp || d_resp) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", {i_resp, d_resp}, 2'b00);
      end else begin
        e = sb.pop_front();
        check_eq("resp_kind", {i_resp, d_resp}, {~e.is_d, e.is_d});
        check_eq("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        check_eq("other_rdata_zero", e.is_d ? i_rdata : d_rdata, 32'h0);
      end
      resp_cnt++;
      prev_resp = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_wmask = '0;

    // Reset state
    @(negedge clk);
    check_eq("reset_outputs",
             {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
              i_resp, d_resp, i_rdata, d_rdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-transaction, then re-grant
    mem_lat = 5;
    i_read = 1'b1; i_address = 32'h60;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("serve_i_before_reset", {pmem_read, pmem_address}, {1'b1, 32'h60});
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_outputs",
             {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
              i_resp, d_resp, i_rdata, d_rdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_resp(1'b0, mem_data(32'h60));
    @(posedge clk); #1;
    check_eq("regrant_addr", {pmem_read, pmem_address}, {1'b1, 32'h60});
    wait_resp(exp_resps);
    i_read = 1'b0;

    // Lone fetch, latency 3
    mem_lat = 3;
    i_read = 1'b1; i_address = 32'h40;
    expect_resp(1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check_eq("fetch_c1_strobe", {pmem_read, pmem_write, pmem_address},
             {2'b10, 32'h40});
    @(negedge clk);
    check_eq("fetch_c1_noresp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    check_eq("fetch_c2_noresp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    check_eq("fetch_c3_resp", {i_resp, d_resp, i_rdata}, {2'b10, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    i_read = 1'b0;
    wait_resp(exp_resps);

    // Store with live input change mid-transaction
    mem_lat = 4;
    d_write = 1'b1; d_address = 32'h100; d_wdata = 32'h1234_5678; d_wmask = 4'b0011;
    expect_resp(1'b1, mem_data(32'h100));
    @(posedge clk); #1;
    d_wdata = 32'hFFFF_FFFF; d_wmask = 4'b1100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq("store_hold",
               {pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_wmask},
               {2'b10, 32'h100, 32'h1234_5678, 4'b0011});
    end
    @(posedge clk); #1;
    d_write = 1'b0; d_wdata = '0; d_wmask = '0;
    wait_resp(exp_resps);

    // Simultaneous requests: D, one IDLE cycle, then I
    mem_lat = 2;
    i_read = 1'b1; i_address = 32'h80;
    d_read = 1'b1; d_address = 32'h200;
    expect_resp(1'b1, mem_data(32'h200));
    expect_resp(1'b0, mem_data(32'h80));
    for (int c = 1; c <= 6; c++) begin
      logic        exp_strobe;
      logic [31:0] exp_addr;
      exp_strobe = (c != 3) && (c != 6);
      exp_addr   = (c <= 2) ? 32'h200 : 32'h80;
      @(posedge clk); #1;
      if (c == 3) d_read = 1'b0;
      if (c == 6) i_read = 1'b0;
      @(negedge clk);
      check_eq("simul_strobe", pmem_read, exp_strobe);
      if (exp_strobe) check_eq("simul_addr", pmem_address, exp_addr);
    end
    wait_resp(exp_resps);

    // Starvation: fetch held, data re-requested every IDLE cycle
    @(posedge clk); #1;
    mem_lat = 1;
    i_address = 32'h84; d_address = 32'h300;
`ifdef ARB_STARVE_GUARD_EN
    expect_resp(1'b1, mem_data(32'h300));
    expect_resp(1'b1, mem_data(32'h300));
    expect_resp(1'b0, mem_data(32'h84));
    expect_resp(1'b1, mem_data(32'h300));
`else
    for (int k = 0; k < 10; k++) expect_resp(1'b1, mem_data(32'h300));
`endif
    i_read = 1'b1; d_read = 1'b1;
    wait_resp(exp_resps);
    i_read = 1'b0; d_read = 1'b0;

    repeat (3) begin @(posedge clk); #1; end
    check_eq("scoreboard_empty", 160'(sb.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
